// File: rtl/ft245_pkg.sv
// ----------------------------------------------------------------------------
// ft245_pkg
// Shared types and constants for the FT245-style async FIFO bus engines.
//   - ft_state_e    : write-engine sequencing states
//   - FT_DW         : bus data width
//   - FT_*_DEF      : default timing, in clk100 cycles at 100 MHz
//   - ft_cnt_load   : down-counter preload for an N-cycle phase
//   - ft_max4       : largest of four phase lengths (sizes the timer)
// ----------------------------------------------------------------------------
package ft245_pkg;

    localparam int FT_DW = 8;

    localparam int FT_FIFO_DEPTH_DEF = 16;
    localparam int FT_SETUP_CYC_DEF  = 2;   // >= 20 ns data setup before WR rise
    localparam int FT_WR_HI_CYC_DEF  = 6;   // >= 50 ns WR high
    localparam int FT_HOLD_CYC_DEF   = 1;   // data hold after WR fall
    localparam int FT_RECOV_CYC_DEF  = 10;  // TXE# high period + synchronizer

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } ft_state_e;

    // A phase of N cycles runs the counter from N-1 down to 0; a zero-length
    // phase still occupies one cycle.
    function automatic int ft_cnt_load(input int cyc);
        return (cyc > 0) ? (cyc - 1) : 0;
    endfunction

    function automatic int ft_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ft_byte_fifo.sv
// ----------------------------------------------------------------------------
// ft_byte_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata whenever empty is low; pop advances to the next entry. Shared by the
// FT245 write path and the read path.
//   clk, rst_n : clock, async active-low reset (flushes the FIFO)
//   push/wdata : write request, refused while full
//   pop/rdata  : read request and head data, ignored while empty
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module ft_byte_fifo
    import ft245_pkg::*;
#(
    parameter int DEPTH = FT_FIFO_DEPTH_DEF,
    parameter int DW    = FT_DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: a flush is just the pointer reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ft245_tx.sv
// ----------------------------------------------------------------------------
// ft245_tx
// FPGA-to-host write engine for the FT245 async FIFO bus. Bytes from fabric
// logic are queued in a local FIFO and each one is emitted as a single bus
// write cycle timed in clk100 cycles.
//
// Ports:
//   clk100, rst_n      : 100 MHz clock, async active-low reset
//   tx_data/tx_valid   : byte stream in; accepted when tx_valid && tx_ready
//   tx_ready           : FIFO not full
//   rd_active          : read path owns the bus, blocks new write cycles
//   wr_busy            : write cycle in progress, or one starting this cycle
//   FT_TX_Enable_n     : TXE#, async, low = host can take a byte
//   FT_PWR_n           : async, low = host-side device configured
//   FT_DATA_OUT/OE     : bus data and per-bit output enable
//   FT_WR_Strobe       : WR, active high, host latches on the falling edge
//   fifo_level         : FIFO occupancy
// Build option FT245_TX_STATS_EN adds tx_count (writes completed, wrapping)
// and stall_count (IDLE cycles with data waiting but blocked, saturating).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for data, TXE# low, PWR# low and no read in progress
// SETUP   | data and OE driven ahead of the WR rising edge
// STROBE  | WR high
// HOLD    | WR low, data and OE still driven
// RECOVER | bus released, TXE# ignored until the host has deasserted it
// ----------------------------------------------------------------------------
module ft245_tx
    import ft245_pkg::*;
#(
    parameter int FIFO_DEPTH = FT_FIFO_DEPTH_DEF,
    parameter int SETUP_CYC  = FT_SETUP_CYC_DEF,
    parameter int WR_HI_CYC  = FT_WR_HI_CYC_DEF,
    parameter int HOLD_CYC   = FT_HOLD_CYC_DEF,
    parameter int RECOV_CYC  = FT_RECOV_CYC_DEF
) (
    input  logic                         clk100,
    input  logic                         rst_n,
    input  logic [FT_DW-1:0]             tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic                         rd_active,
    output logic                         wr_busy,
    input  logic                         FT_TX_Enable_n,
    input  logic                         FT_PWR_n,
    output logic [FT_DW-1:0]             FT_DATA_OUT,
    output logic [FT_DW-1:0]             FT_DATA_OE,
    output logic                         FT_WR_Strobe,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef FT245_TX_STATS_EN
    ,
    output logic [31:0]                  tx_count,
    output logic [15:0]                  stall_count
`endif
);

    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int MAX_CYC = ft_max4(SETUP_CYC, WR_HI_CYC, HOLD_CYC, RECOV_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(ft_cnt_load(SETUP_CYC));
    localparam logic [CNT_W-1:0] LD_WR_HI = CNT_W'(ft_cnt_load(WR_HI_CYC));
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(ft_cnt_load(HOLD_CYC));
    localparam logic [CNT_W-1:0] LD_RECOV = CNT_W'(ft_cnt_load(RECOV_CYC));

    // ------------------------------------------------------------------
    // Synchronizers: reset to 1 so the bus reads as "not ready".
    // ------------------------------------------------------------------
    logic [1:0] txe_sync_q;
    logic [1:0] pwr_sync_q;
    logic       txe_sync;
    logic       pwr_sync;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            txe_sync_q <= 2'b11;
            pwr_sync_q <= 2'b11;
        end else begin
            txe_sync_q <= {txe_sync_q[0], FT_TX_Enable_n};
            pwr_sync_q <= {pwr_sync_q[0], FT_PWR_n};
        end
    end

    assign txe_sync = txe_sync_q[1];
    assign pwr_sync = pwr_sync_q[1];

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic             fifo_full;
    logic             fifo_empty;
    logic [FT_DW-1:0] fifo_rdata;
    logic [LVL_W-1:0] fifo_lvl;
    logic             start;

    assign tx_ready = !fifo_full;

    ft_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (FT_DW)
    ) u_fifo (
        .clk   (clk100),
        .rst_n (rst_n),
        .push  (tx_valid && !fifo_full),
        .wdata (tx_data),
        .pop   (start),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

    assign fifo_level = fifo_lvl;

    // ------------------------------------------------------------------
    // Write-cycle FSM
    // ------------------------------------------------------------------
    ft_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_done;

    logic [FT_DW-1:0] data_q, data_d;
    logic [FT_DW-1:0] oe_q, oe_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;

    // rd_active in the start term gives the read path priority on a tie.
    assign start    = (state_q == IDLE) && !fifo_empty && !txe_sync
                      && !pwr_sync && !rd_active;
    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            oe_q    <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    state_d = STROBE;
                    cnt_d   = LD_WR_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_done) begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    state_d = RECOVER;
                    cnt_d   = LD_RECOV;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin drivers are decoded from the next state so they leave registers
    // aligned with the state they belong to.
    always_comb begin
        data_d = data_q;
        oe_d   = '0;
        wr_d   = 1'b0;
        busy_d = 1'b0;
        if (start) data_d = fifo_rdata;
        if (state_d == SETUP || state_d == STROBE || state_d == HOLD) begin
            oe_d   = '1;
            busy_d = 1'b1;
        end
        if (state_d == STROBE) wr_d = 1'b1;
    end

    assign FT_DATA_OUT  = data_q;
    assign FT_DATA_OE   = oe_q;
    assign FT_WR_Strobe = wr_q;
    // The registered flag lags the IDLE->SETUP decision by one cycle, so the
    // start term is folded in for the read path's benefit.
    assign wr_busy      = busy_q | start;

`ifdef FT245_TX_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [31:0] tx_count_q;
    logic [15:0] stall_count_q;
    logic        wr_fall;
    logic        stall;

    assign wr_fall = (state_q == STROBE) && (state_d == HOLD);
    assign stall   = (state_q == IDLE) && !fifo_empty
                     && (txe_sync || pwr_sync || rd_active);

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            if (wr_fall) tx_count_q <= tx_count_q + 32'd1;
            if (stall && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign tx_count    = tx_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ft245_tx.sv
module tb_ft245_tx;

    localparam int S     = 2;
    localparam int W     = 6;
    localparam int H     = 1;
    localparam int R     = 10;
    localparam int DEPTH = 16;
    localparam int T_END = S + W + H + R;

    logic       clk100 = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rd_active;
    logic       wr_busy;
    logic       FT_TX_Enable_n;
    logic       FT_PWR_n;
    logic [7:0] FT_DATA_OUT;
    logic [7:0] FT_DATA_OE;
    logic       FT_WR_Strobe;
    logic [4:0] fifo_level;
`ifdef FT245_TX_STATS_EN
    logic [31:0] tx_count;
    logic [15:0] stall_count;
`endif

    always #5 clk100 = ~clk100;

    ft245_tx dut (
        .clk100         (clk100),
        .rst_n          (rst_n),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rd_active      (rd_active),
        .wr_busy        (wr_busy),
        .FT_TX_Enable_n (FT_TX_Enable_n),
        .FT_PWR_n       (FT_PWR_n),
        .FT_DATA_OUT    (FT_DATA_OUT),
        .FT_DATA_OE     (FT_DATA_OE),
        .FT_WR_Strobe   (FT_WR_Strobe),
        .fifo_level     (fifo_level)
`ifdef FT245_TX_STATS_EN
        ,
        .tx_count       (tx_count),
        .stall_count    (stall_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a queue of accepted bytes plus the age (in cycles) of the
    // write cycle in flight; -1 means no cycle is in flight.
    // ------------------------------------------------------------------
    logic [7:0] m_q [$];
    int         m_tl = -1;
    logic [7:0] m_cur = 8'h00;
    logic       m_txe1 = 1'b1, m_txe2 = 1'b1, m_pwr1 = 1'b1, m_pwr2 = 1'b1;
    logic [31:0] m_txc = 0;
    logic [15:0] m_stall = 0;

    int         rise_cyc  [$];
    logic [7:0] rise_byte [$];
    int         rise_lvl  [$];
    logic       wr_prev = 1'b0;

    always begin
        logic st, push_ok, exp_start, exp_drive, exp_wr;
        @(posedge clk100);
        #1;
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_tl = -1; m_cur = 8'h00;
            m_txe1 = 1'b1; m_txe2 = 1'b1; m_pwr1 = 1'b1; m_pwr2 = 1'b1;
            m_txc = 0; m_stall = 0;
        end else begin
            st = (m_tl < 0) && (m_q.size() > 0) && !m_txe2 && !m_pwr2 && !rd_active;
            if ((m_tl < 0) && (m_q.size() > 0) && (m_txe2 || m_pwr2 || rd_active)
                && m_stall != 16'hFFFF)
                m_stall++;
            if (m_tl == S + W - 1) m_txc++;
            push_ok = tx_valid && (m_q.size() < DEPTH);
            if (st) begin
                m_cur = m_q.pop_front();
                m_tl  = 0;
            end else if (m_tl >= 0) begin
                m_tl++;
                if (m_tl >= T_END) m_tl = -1;
            end
            if (push_ok) m_q.push_back(tx_data);
            m_txe2 = m_txe1; m_txe1 = FT_TX_Enable_n;
            m_pwr2 = m_pwr1; m_pwr1 = FT_PWR_n;
        end

        exp_wr    = (m_tl >= S) && (m_tl < S + W);
        exp_drive = (m_tl >= 0) && (m_tl < S + W + H);
        exp_start = (m_tl < 0) && (m_q.size() > 0) && !m_txe2 && !m_pwr2 && !rd_active;
        check("wr",       FT_WR_Strobe, exp_wr);
        check("oe",       FT_DATA_OE,   exp_drive ? 8'hFF : 8'h00);
        if (exp_drive) check("data", FT_DATA_OUT, m_cur);
        check("wr_busy",  wr_busy,      exp_drive || exp_start);
        check("level",    fifo_level,   m_q.size());
        check("tx_ready", tx_ready,     m_q.size() < DEPTH);
`ifdef FT245_TX_STATS_EN
        check("tx_count",    tx_count,    m_txc);
        check("stall_count", stall_count, m_stall);
`endif
        if (FT_WR_Strobe && !wr_prev) begin
            rise_cyc.push_back(cyc);
            rise_byte.push_back(FT_DATA_OUT);
            rise_lvl.push_back(int'(fifo_level));
        end
        wr_prev = FT_WR_Strobe;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: everything is driven just after a falling edge.
    // ------------------------------------------------------------------
    task automatic nclk(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic push1(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk100);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!(m_tl < 0 && m_q.size() == 0) && k < budget) begin
            @(negedge clk100);
            k++;
        end
        check("drain_in_budget", k < budget, 1);
    endtask

    task automatic wait_wr(input int budget);
        int k = 0;
        while (!FT_WR_Strobe && k < budget) begin
            @(negedge clk100);
            k++;
        end
        check("wr_rise_in_budget", FT_WR_Strobe, 1);
    endtask

    task automatic count_wr_high(output int hi);
        hi = 0;
        while (FT_WR_Strobe && hi < 20) begin
            @(negedge clk100);
            hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, hi, r0;
        logic [7:0] b;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rd_active = 1'b0;
        FT_TX_Enable_n = 1'b1; FT_PWR_n = 1'b1;
        nclk(3);
        check("rst_wr",   FT_WR_Strobe, 0);
        check("rst_oe",   FT_DATA_OE,   0);
        check("rst_data", FT_DATA_OUT,  0);
        check("rst_busy", wr_busy,      0);
        check("rst_lvl",  fifo_level,   0);
        rst_n = 1'b1;
        nclk(1);
        check("rst_ready", tx_ready, 1);

        // Single byte: latency, WR width, hold, release
        FT_PWR_n = 1'b0;
        push1(8'hA5);
        nclk(3);
        check("t1_no_wr_while_txe_hi", FT_DATA_OE, 8'h00);
        FT_TX_Enable_n = 1'b0;
        n = 0;
        while (FT_DATA_OE != 8'hFF && n < 10) begin
            @(negedge clk100);
            n++;
        end
        check("t1_oe_latency", n, 3);
        check("t1_data", FT_DATA_OUT, 8'hA5);
        wait_wr(10);
        count_wr_high(hi);
        check("t1_wr_high_cycles", hi, 6);
        check("t1_hold_oe",   FT_DATA_OE,  8'hFF);
        check("t1_hold_data", FT_DATA_OUT, 8'hA5);
        nclk(1);
        check("t1_oe_off",   FT_DATA_OE, 8'h00);
        check("t1_busy_off", wr_busy,    0);
        wait_done(100);

        // Three bytes back to back
        FT_TX_Enable_n = 1'b1;
        nclk(3);
        r0 = rise_cyc.size();
        push1(8'h01); push1(8'h02); push1(8'h03);
        check("t2_level3", fifo_level, 3);
        FT_TX_Enable_n = 1'b0;
        wait_done(200);
        check("t2_pulses", rise_cyc.size() - r0, 3);
        if (rise_cyc.size() - r0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t2_byte", rise_byte[r0+i], i + 1);
                check("t2_level_at_rise", rise_lvl[r0+i], 2 - i);
                if (i > 0) check("t2_rise_spacing", rise_cyc[r0+i] - rise_cyc[r0+i-1], 20);
            end
        end

        // Fill to full with TXE# high, then drain
        FT_TX_Enable_n = 1'b1;
        nclk(3);
        r0 = rise_cyc.size();
        for (int i = 0; i < 16; i++) begin
            b = 8'h10 + 8'(i);
            push1(b);
        end
        check("t3_level16", fifo_level, 16);
        check("t3_not_ready", tx_ready, 0);
        push1(8'hEE);
        check("t3_refused", fifo_level, 16);
        nclk(5);
        check("t3_no_wr", rise_cyc.size() - r0, 0);
        FT_TX_Enable_n = 1'b0;
        wait_done(16 * 20 + 100);
        check("t3_pulses", rise_cyc.size() - r0, 16);
        if (rise_cyc.size() - r0 == 16)
            for (int i = 0; i < 16; i++) check("t3_byte", rise_byte[r0+i], 8'h10 + i);

        // rd_active priority, then rd_active during STROBE
        rd_active = 1'b1;
        push1(8'h55);
        nclk(4);
        check("t4_blocked", FT_DATA_OE, 8'h00);
        rd_active = 1'b0;
        #1;
        check("t4_busy_comb", wr_busy, 1);
        nclk(1);
        check("t4_start_oe", FT_DATA_OE, 8'hFF);
        check("t4_start_data", FT_DATA_OUT, 8'h55);
        wait_done(100);
        push1(8'h66);
        wait_wr(20);
        rd_active = 1'b1;
        count_wr_high(hi);
        check("t4_strobe_intact", hi, 6);
        check("t4_hold_data", FT_DATA_OUT, 8'h66);
        rd_active = 1'b0;
        wait_done(100);

        // PWR# high blocks writes and keeps contents
        FT_PWR_n = 1'b1;
        nclk(3);
        r0 = rise_cyc.size();
        push1(8'h99);
        nclk(10);
        check("t5_pwr_level", fifo_level, 1);
        check("t5_pwr_no_wr", rise_cyc.size() - r0, 0);
        FT_PWR_n = 1'b0;
        wait_done(100);
        check("t5_pwr_byte", rise_byte[rise_byte.size()-1], 8'h99);

        // Reset during STROBE
        push1(8'h71); push1(8'h72); push1(8'h73);
        wait_wr(20);
        nclk(2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr",    FT_WR_Strobe, 0);
        check("t6_rst_oe",    FT_DATA_OE,   8'h00);
        check("t6_rst_busy",  wr_busy,      0);
        check("t6_rst_level", fifo_level,   0);
        nclk(1);
        rst_n = 1'b1;
        r0 = rise_cyc.size();
        nclk(40);
        check("t6_no_more_wr", rise_cyc.size() - r0, 0);

`ifdef FT245_TX_STATS_EN
        // Four bytes behind a ten-cycle TXE# stall
        FT_TX_Enable_n = 1'b1;
        nclk(3);
        check("t7_txc0", tx_count, 0);
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'hC0 + 8'(i);
            nclk(1);
        end
        tx_valid = 1'b0;
        nclk(5);
        FT_TX_Enable_n = 1'b0;
        wait_done(200);
        check("t7_tx_count", tx_count, 4);
        check("t7_stall_count", stall_count, 10);
`endif

        nclk(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
